// File: rtl/fb_pkg.sv
// Shared DDRAM geometry, queue entry type and issue-FSM states for the
// framebuffer write queue.
package fb_pkg;

  localparam int unsigned DDRAM_AW = 29;
  localparam int unsigned DDRAM_DW = 64;
  localparam int unsigned DDRAM_BW = DDRAM_DW / 8;

  typedef struct packed {
    logic [DDRAM_AW-1:0] addr;
    logic [DDRAM_DW-1:0] data;
    logic [DDRAM_BW-1:0] be;
  } fb_wrq_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } fb_wrq_state_e;

  // Replace only the bytes whose enable is set.
  function automatic logic [DDRAM_DW-1:0] merge_bytes(
    input logic [DDRAM_DW-1:0] old_data,
    input logic [DDRAM_DW-1:0] new_data,
    input logic [DDRAM_BW-1:0] be
  );
    logic [DDRAM_DW-1:0] r;
    r = old_data;
    for (int unsigned i = 0; i < DDRAM_BW; i++) begin
      if (be[i]) r[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_wrq_fifo.sv
// Synchronous entry FIFO with a registered head output; the head stays in
// the FIFO (and in level) until it is popped.
module fb_wrq_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fb_wrq_entry_t          push_data,
  input  logic                   pop,
  output fb_wrq_entry_t          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  fb_wrq_entry_t mem_q [DEPTH];
  fb_wrq_entry_t mem_d [DEPTH];
  fb_wrq_entry_t head_q, head_d;
  logic          do_push, do_pop;
  logic [AW-1:0] wr_idx, rd_next_idx;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign head  = head_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, do_pop};
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, do_push};
    wr_idx      = wr_ptr_q[AW-1:0];
    rd_next_idx = rd_ptr_d[AW-1:0];
    mem_d       = mem_q;
    if (do_push) mem_d[wr_idx] = push_data;
    // A push landing in the next head slot only happens when the FIFO would
    // otherwise be empty, so forward it straight into the head register.
    if (do_push && (wr_idx == rd_next_idx)) head_d = push_data;
    else                                    head_d = mem_q[rd_next_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fb_write_queue.sv
// Framebuffer write queue: buffers rotation-writer words and issues them as
// single-beat DDRAM writes. Define FB_WRQ_MERGE_EN for same-address byte merging.
module fb_write_queue
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned HOLD_CYC = 8
) (
  input  logic                   CLK_VIDEO,
  input  logic                   RESET_N,
  input  logic                   in_valid,
  input  logic [DDRAM_AW-1:0]    in_addr,
  input  logic [DDRAM_DW-1:0]    in_data,
  input  logic [DDRAM_BW-1:0]    in_be,
  input  logic                   DDRAM_BUSY,
  output logic                   DDRAM_WE,
  output logic [DDRAM_AW-1:0]    DDRAM_ADDR,
  output logic [DDRAM_DW-1:0]    DDRAM_DIN,
  output logic [DDRAM_BW-1:0]    DDRAM_BE,
  output logic [7:0]             DDRAM_BURSTCNT,
  output logic                   DDRAM_RD,
  input  logic                   clr_stat,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [$clog2(DEPTH):0] LVL_ONE = 1;

  if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || HOLD_CYC == 0) begin : g_bad_cfg
    $error("fb_write_queue: unsupported DEPTH/HOLD_CYC");
  end

  fb_wrq_state_e state_q, state_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic                   push_req, push_fire, pop, drop, xfer_done;
  fb_wrq_entry_t          push_entry, head;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;

  fb_wrq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CLK_VIDEO),
    .rst_n    (RESET_N),
    .push     (push_req),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

`ifdef FB_WRQ_MERGE_EN
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic              pend_valid_q, pend_valid_d;
  fb_wrq_entry_t     pend_q, pend_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  fb_wrq_entry_t     incoming, merged;

  always_comb begin
    incoming     = '{addr: in_addr, data: in_data, be: in_be};
    merged       = '{addr: pend_q.addr,
                     data: merge_bytes(pend_q.data, in_data, in_be),
                     be:   pend_q.be | in_be};
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    hold_cnt_d   = hold_cnt_q;
    push_req     = 1'b0;
    push_entry   = pend_q;
    if (in_valid) begin
      hold_cnt_d = '0;
      if (pend_valid_q && (in_addr == pend_q.addr)) begin
        if (&merged.be) begin
          push_req     = 1'b1;
          push_entry   = merged;
          pend_valid_d = 1'b0;
        end else begin
          pend_d = merged;
        end
      end else if (pend_valid_q) begin
        push_req = 1'b1;
        pend_d   = incoming;
      end else if (&in_be) begin
        push_req   = 1'b1;
        push_entry = incoming;
      end else begin
        pend_valid_d = 1'b1;
        pend_d       = incoming;
      end
    end else if (pend_valid_q) begin
      // A full-BE word left pending by an address change flushes on the next idle cycle.
      if ((&pend_q.be) || (hold_cnt_q == HOLD_W'(HOLD_CYC - 1))) begin
        push_req     = 1'b1;
        pend_valid_d = 1'b0;
        hold_cnt_d   = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      hold_cnt_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end
`else
  assign push_req   = in_valid;
  assign push_entry = '{addr: in_addr, data: in_data, be: in_be};
`endif

  assign xfer_done = (state_q == ST_ISSUE) && !DDRAM_BUSY;
  assign pop       = xfer_done;
  assign push_fire = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: if (xfer_done && (fifo_level == LVL_ONE) && !push_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_stat)         drop_cnt_d = 16'd1;
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_stat) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DDRAM_WE       = (state_q == ST_ISSUE);
  assign DDRAM_ADDR     = head.addr;
  assign DDRAM_DIN      = head.data;
  assign DDRAM_BE       = head.be;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;
  assign level          = fifo_level;

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed self-checking bench for fb_write_queue (DEPTH=16, HOLD_CYC=8).
module tb_fb_write_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [28:0] in_addr = '0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_be = '0;
  logic        busy = 1'b0;
  logic        clr_stat = 1'b0;
  logic        we;
  logic [28:0] ddr_addr;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_be;
  logic [7:0]  burstcnt;
  logic        ddr_rd;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [4:0]  level;

  int tests_run = 0;
  int tests_failed = 0;
  int xfer_cnt = 0;
  logic [28:0] mon_addr [64];
  logic [63:0] mon_data [64];
  logic [7:0]  mon_be   [64];

  fb_write_queue #(.DEPTH(16), .HOLD_CYC(8)) dut (
    .CLK_VIDEO(clk), .RESET_N(rst_n),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_be(in_be),
    .DDRAM_BUSY(busy), .DDRAM_WE(we), .DDRAM_ADDR(ddr_addr), .DDRAM_DIN(ddr_din),
    .DDRAM_BE(ddr_be), .DDRAM_BURSTCNT(burstcnt), .DDRAM_RD(ddr_rd),
    .clr_stat(clr_stat), .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  // Completion happens at the next rising edge when WE=1 and BUSY=0 at mid-cycle.
  always @(negedge clk) begin
    if (rst_n && we && !busy) begin
      if (xfer_cnt < 64) begin
        mon_addr[xfer_cnt] = ddr_addr;
        mon_data[xfer_cnt] = ddr_din;
        mon_be[xfer_cnt]   = ddr_be;
      end
      xfer_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; busy = 1'b0; clr_stat = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    in_valid = 1'b1; in_addr = a; in_data = d; in_be = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", we); end
    tests_run++; if (ddr_addr !== 29'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", ddr_addr); end
    tests_run++; if (ddr_din !== 64'h0) begin tests_failed++; $display("FAIL reset_din: got %h want 0", ddr_din); end
    tests_run++; if (ddr_be !== 8'h0) begin tests_failed++; $display("FAIL reset_be: got %h want 0", ddr_be); end
    tests_run++; if (burstcnt !== 8'd1) begin tests_failed++; $display("FAIL burstcnt: got %0d want 1", burstcnt); end
    tests_run++; if (ddr_rd !== 1'b0) begin tests_failed++; $display("FAIL rd: got %b want 0", ddr_rd); end
    tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int base;
    do_reset();
    base = xfer_cnt;
    write(29'h100, 64'h11, 8'h0F);
    step();
    in_valid = 1'b0;
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL single_we_early: got %b want 0", we); end
    tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL single_level1: got %0d want 1", level); end
    step();
    tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL single_we_2cyc: got %b want 1", we); end
    tests_run++; if (ddr_addr !== 29'h100 || ddr_din !== 64'h11 || ddr_be !== 8'h0F) begin
      tests_failed++; $display("FAIL single_payload: got %h/%h/%h want 100/11/0f", ddr_addr, ddr_din, ddr_be);
    end
    step();
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL single_we_after: got %b want 0", we); end
    tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL single_level0: got %0d want 0", level); end
    step(); step();
    tests_run++; if (xfer_cnt - base !== 1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", xfer_cnt - base); end
  endtask

  task automatic test_back_to_back();
    logic [28:0] exp_a [3];
    exp_a[0] = 29'h0A0; exp_a[1] = 29'h0B0; exp_a[2] = 29'h0C0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write(exp_a[i], 64'h5500 + 64'(i), 8'hFF);
      step();
    end
    in_valid = 1'b0;
    // Edges E0..E2 done: A is on the bus since E1, B since E2.
    tests_run++; if (we !== 1'b1 || ddr_addr !== exp_a[1]) begin
      tests_failed++; $display("FAIL b2b_second: got we=%b addr=%h want 1/%h", we, ddr_addr, exp_a[1]);
    end
    step();
    tests_run++; if (we !== 1'b1 || ddr_addr !== exp_a[2]) begin
      tests_failed++; $display("FAIL b2b_third: got we=%b addr=%h want 1/%h", we, ddr_addr, exp_a[2]);
    end
    step();
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b want 0", we); end
    tests_run++; if (mon_addr[xfer_cnt-3] !== exp_a[0]) begin
      tests_failed++; $display("FAIL b2b_first: got %h want %h", mon_addr[xfer_cnt-3], exp_a[0]);
    end
  endtask

  task automatic test_busy_hold();
    int base;
    do_reset();
    base = xfer_cnt;
    busy = 1'b1;
    write(29'h200, 64'hCAFE_F00D_1234_5678, 8'hFF);
    step();
    in_valid = 1'b0;
    step();
    tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL busy_we: got %b want 1", we); end
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++;
      if (we !== 1'b1 || ddr_addr !== 29'h200 || ddr_din !== 64'hCAFE_F00D_1234_5678 || ddr_be !== 8'hFF) begin
        tests_failed++;
        $display("FAIL busy_stable[%0d]: got %b/%h/%h/%h want 1/200/cafef00d12345678/ff", k, we, ddr_addr, ddr_din, ddr_be);
      end
    end
    tests_run++; if (xfer_cnt !== base) begin tests_failed++; $display("FAIL busy_no_xfer: got %0d want %0d", xfer_cnt, base); end
    busy = 1'b0;
    step();
    tests_run++; if (xfer_cnt - base !== 1) begin tests_failed++; $display("FAIL busy_done: got %0d want 1", xfer_cnt - base); end
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL busy_we_off: got %b want 0", we); end
    step(); step();
    tests_run++; if (xfer_cnt - base !== 1) begin tests_failed++; $display("FAIL busy_single: got %0d want 1", xfer_cnt - base); end
  endtask

  task automatic test_overflow();
    int base;
    int guard;
    do_reset();
    base = xfer_cnt;
    busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write(29'h1000 + 29'(i), 64'hD000 + 64'(i), 8'hFF);
      step();
    end
    in_valid = 1'b0;
    tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL ovf_level: got %0d want 16", level); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    tests_run++; if (drop_cnt !== 16'd4) begin tests_failed++; $display("FAIL ovf_drop_cnt: got %0d want 4", drop_cnt); end
    // A drop coinciding with clr_stat leaves exactly one counted drop.
    write(29'h1FFF, 64'hBAD, 8'hFF);
    clr_stat = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL clr_with_drop: got %b/%0d want 1/1", overflow, drop_cnt);
    end
    step();
    clr_stat = 1'b0;
    tests_run++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL clr_alone: got %b/%0d want 0/0", overflow, drop_cnt);
    end
    // Push while full and a completion pops in the same cycle: accepted.
    busy = 1'b0;
    write(29'h2000, 64'hE000, 8'hFF);
    step();
    in_valid = 1'b0;
    tests_run++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL full_push_pop: got %b/%0d want 0/0", overflow, drop_cnt);
    end
    tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL full_push_pop_level: got %0d want 16", level); end
    guard = 0;
    while (xfer_cnt - base < 17 && guard < 40) begin step(); guard++; end
    step(); step();
    tests_run++; if (xfer_cnt - base !== 17) begin tests_failed++; $display("FAIL ovf_xfer_count: got %0d want 17", xfer_cnt - base); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (mon_addr[base+i] !== 29'h1000 + 29'(i) || mon_data[base+i] !== 64'hD000 + 64'(i)) begin
        tests_failed++;
        $display("FAIL ovf_order[%0d]: got %h/%h want %h/%h", i, mon_addr[base+i], mon_data[base+i], 29'h1000 + 29'(i), 64'hD000 + 64'(i));
      end
    end
    tests_run++; if (mon_addr[base+16] !== 29'h2000) begin tests_failed++; $display("FAIL ovf_last: got %h want 2000", mon_addr[base+16]); end
    tests_run++; if (we !== 1'b0 || level !== 5'd0) begin tests_failed++; $display("FAIL ovf_drained: got %b/%0d want 0/0", we, level); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    base = xfer_cnt;
    busy = 1'b1;
    write(29'h500, 64'h77, 8'hFF);
    step();
    in_valid = 1'b0;
    step();
    tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL rstmid_we_pre: got %b want 1", we); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL rstmid_we: got %b want 0", we); end
    tests_run++; if (level !== 5'd0 || ddr_addr !== 29'h0) begin tests_failed++; $display("FAIL rstmid_clear: got %0d/%h want 0/0", level, ddr_addr); end
    step(); step();
    rst_n = 1'b1;
    busy = 1'b0;
    repeat (6) step();
    tests_run++; if (xfer_cnt !== base) begin tests_failed++; $display("FAIL rstmid_no_xfer: got %0d want %0d", xfer_cnt, base); end
    tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL rstmid_we_after: got %b want 0", we); end
  endtask

`ifdef FB_WRQ_MERGE_EN
  task automatic test_merge_combine();
    int base;
    int guard;
    do_reset();
    base = xfer_cnt;
    write(29'h300, 64'h7777_7777_AABB_CCDD, 8'h0F);
    step();
    write(29'h300, 64'h1122_3344_9999_9999, 8'hF0);
    step();
    in_valid = 1'b0;
    guard = 0;
    while (xfer_cnt == base && guard < 20) begin step(); guard++; end
    step(); step(); step();
    tests_run++; if (xfer_cnt - base !== 1) begin tests_failed++; $display("FAIL merge_count: got %0d want 1", xfer_cnt - base); end
    tests_run++;
    if (mon_addr[base] !== 29'h300 || mon_data[base] !== 64'h1122_3344_AABB_CCDD || mon_be[base] !== 8'hFF) begin
      tests_failed++;
      $display("FAIL merge_payload: got %h/%h/%h want 300/11223344aabbccdd/ff", mon_addr[base], mon_data[base], mon_be[base]);
    end
  endtask

  task automatic test_merge_hold();
    do_reset();
    write(29'h400, 64'h42, 8'h0F);
    step();
    in_valid = 1'b0;
    // Pushed after the 8th idle edge, WE follows one edge later.
    for (int k = 1; k <= 9; k++) begin
      step();
      tests_run++;
      if (we !== (k == 9)) begin
        tests_failed++; $display("FAIL merge_hold[%0d]: got we=%b want %b", k, we, (k == 9));
      end
    end
    tests_run++; if (ddr_addr !== 29'h400 || ddr_be !== 8'h0F) begin
      tests_failed++; $display("FAIL merge_hold_payload: got %h/%h want 400/0f", ddr_addr, ddr_be);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FB_WRQ_MERGE_EN
    test_single();
`endif
    test_back_to_back();
    test_busy_hold();
    test_overflow();
    test_reset_mid();
`ifdef FB_WRQ_MERGE_EN
    test_merge_combine();
    test_merge_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fb_write_queue.md
FB_WRITE_QUEUE -- requirements
Module: fb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter HOLD_CYC, default 8, idle cycles before a partial merge word is flushed.
REQ-003 SHALL have ports CLK_VIDEO in 1 (sole clock) and RESET_N in 1 (asynchronous, active-low reset).
REQ-004 SHALL have port in_valid in 1, a single write request per cycle from the rotation writer; it has no stall path.
REQ-005 SHALL have port in_addr in 29, 64-bit word address.
REQ-006 SHALL have ports in_data in 64 and in_be in 8 (byte enables).
REQ-007 SHALL have ports DDRAM_BUSY in 1, DDRAM_WE out 1, DDRAM_ADDR out 29, DDRAM_DIN out 64, DDRAM_BE out 8, DDRAM_BURSTCNT out 8, and DDRAM_RD out 1.
REQ-008 SHALL have status ports clr_stat in 1, overflow out 1, drop_cnt out 16, and level out $clog2(DEPTH)+1.

Function
REQ-009 SHALL drive DDRAM_BURSTCNT constant 1 and DDRAM_RD constant 0.
REQ-010 SHALL use a two-state issue FSM: IDLE to ISSUE when FIFO non-empty; ISSUE to IDLE when WE=1 and BUSY=0 and FIFO empty; otherwise stay in ISSUE.
REQ-011 SHALL hold DDRAM_WE, ADDR, DIN and BE stable while DDRAM_BUSY=1; a transfer completes only on a cycle with WE=1 and BUSY=0.
REQ-012 SHALL, when the FIFO is non-empty at transfer completion, present the next entry on the following cycle (back-to-back, no bubble).
REQ-013 SHALL, without merging, assert DDRAM_WE no earlier and no later than 2 cycles after an accepted in_valid into an empty queue with BUSY=0.
REQ-014 SHALL, on in_valid with FIFO full and no concurrent pop, drop the write, set overflow sticky, and increment drop_cnt, saturating at 16'hFFFF.
REQ-015 SHALL treat a simultaneous push and pop at full as a legal push (no drop).
REQ-016 SHALL report in level the entries currently in the FIFO, excluding the merge register.
REQ-017 SHALL clear overflow and drop_cnt on clr_stat=1; a drop in the same cycle wins (overflow=1, drop_cnt=1).
REQ-018 SHALL wrap FIFO pointers modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-019 SHALL, with RESET_N=0, asynchronously clear the FIFO, FSM (IDLE), merge register, overflow, drop_cnt and level, and drive DDRAM_WE=0, ADDR=0, DIN=0, BE=0.
REQ-020 SHALL discard, when reset is asserted mid-transfer (WE=1, BUSY=1), the pending entry, and issue no write after release until a new in_valid.

Configuration
REQ-021 SHALL, with FB_WRQ_MERGE_EN defined, hold one pending word: a write to the pending address ORs BE and replaces enabled bytes.
REQ-022 SHALL, with FB_WRQ_MERGE_EN defined, push the pending word when a write to a different address arrives (the new write becomes pending), when BE reaches 8'hFF, or after HOLD_CYC cycles without in_valid.
REQ-023 SHALL, with FB_WRQ_MERGE_EN defined, make REQ-014 apply at the moment of pushing the pending word.
REQ-024 SHALL, without FB_WRQ_MERGE_EN, push every in_valid straight into the FIFO, with no merge register or hold counter synthesized.

Structure
REQ-025 SHALL place the fb_wrq_entry_t typedef (addr, data, be) and the DDRAM_AW=29 and DDRAM_DW=64 constants in shared package fb_pkg.
REQ-026 SHALL implement storage in one sub-module fb_wrq_fifo (sync FIFO, registered outputs, full/empty/level); the merge and issue logic SHALL stay in the top.

Verification
REQ-027 SHALL cover: single write addr 29'h100, data 64'h11, BE 8'h0F, BUSY=0 (merge off) -> WE=1 exactly 2 cycles later, one transfer, level back to 0.
REQ-028 SHALL cover: BUSY held 1 for 5 cycles during a transfer -> ADDR, DIN and BE unchanged for all 5 cycles; one completion when BUSY drops.
REQ-029 SHALL cover: 20 consecutive writes with BUSY=1, DEPTH=16 -> 16 queued, overflow=1, drop_cnt=4; after BUSY=0, exactly 16 transfers in order.
REQ-030 SHALL cover (merge on): BE 8'h0F then 8'hF0 to the same addr on consecutive cycles -> one transfer with BE 8'hFF and the combined data.
REQ-031 SHALL cover (merge on): a single BE 8'h0F write then idle -> transfer issued after HOLD_CYC=8 idle cycles.
REQ-032 SHALL cover: RESET_N pulsed low while WE=1 and BUSY=1 -> WE=0 immediately, level=0, no transfer after release.
